// File: rtl/image_cache_reader.sv
// image_cache_reader: read-side engine for the frame image cache.
// Scans the cache in raster order (y outer, x inner) through a synchronous read port and
// emits a valid/ready pixel stream with coordinates and frame markers.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   start                      pulse to begin a frame readout (ignored unless idle)
//   busy, done                 busy while scanning/draining; done is a one-cycle end pulse
//   mem_rd_en, mem_rd_addr     cache read strobe and address
//   mem_rd_data                cache read data, valid RD_LATENCY cycles after mem_rd_en
//   pix_valid, pix_ready       output handshake
//   pix_data, pix_x, pix_y     pixel value and absolute coordinates
//   pix_sof, pix_eol, pix_eof  first pixel of frame, last of row, last of frame
// Optional feature macro IMAGE_CACHE_READER_ROI_EN adds roi_x0/roi_x1/roi_y0/roi_y1 inputs,
// sampled on an accepted start, restricting the scan to that inclusive window.
module image_cache_reader #(
  parameter int unsigned ROW_SIZE   = 320,
  parameter int unsigned COL_SIZE   = 240,
  parameter int unsigned WORD_SIZE  = 8,
  parameter int unsigned ROW_WIDTH  = 9,
  parameter int unsigned COL_WIDTH  = 8,
  parameter int unsigned ADDR_WIDTH = 17,
  parameter int unsigned RD_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
`ifdef IMAGE_CACHE_READER_ROI_EN
  input  logic [ROW_WIDTH-1:0]  roi_x0,
  input  logic [ROW_WIDTH-1:0]  roi_x1,
  input  logic [COL_WIDTH-1:0]  roi_y0,
  input  logic [COL_WIDTH-1:0]  roi_y1,
`endif
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [WORD_SIZE-1:0]  mem_rd_data,
  output logic                  pix_valid,
  input  logic                  pix_ready,
  output logic [WORD_SIZE-1:0]  pix_data,
  output logic [ROW_WIDTH-1:0]  pix_x,
  output logic [COL_WIDTH-1:0]  pix_y,
  output logic                  pix_sof,
  output logic                  pix_eol,
  output logic                  pix_eof
);

  localparam int unsigned Depth = RD_LATENCY + 2;
  localparam int unsigned PtrW  = $clog2(Depth);
  localparam int unsigned CntW  = $clog2(Depth + 1);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StScan  = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  typedef struct packed {
    logic [ROW_WIDTH-1:0] x;
    logic [COL_WIDTH-1:0] y;
    logic                 sof;
    logic                 eol;
    logic                 eof;
  } tag_t;

  typedef struct packed {
    logic [WORD_SIZE-1:0] data;
    tag_t                 tag;
  } entry_t;

  logic [1:0]            state_q, state_d;
  logic [ROW_WIDTH-1:0]  x_q, x_start, x_end, x_init;
  logic [COL_WIDTH-1:0]  y_q, y_start, y_end, y_init;
  logic [ADDR_WIDTH-1:0] addr_q, addr_init;
  logic                  empty_roi, start_acc;

  assign start_acc = start && (state_q == StIdle);

`ifdef IMAGE_CACHE_READER_ROI_EN
  logic [ROW_WIDTH-1:0] x0_q, x1_q;
  logic [COL_WIDTH-1:0] y0_q, y1_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x0_q <= '0;
      x1_q <= '0;
      y0_q <= '0;
      y1_q <= '0;
    end else if (start_acc) begin
      x0_q <= roi_x0;
      x1_q <= roi_x1;
      y0_q <= roi_y0;
      y1_q <= roi_y1;
    end
  end

  assign x_start   = x0_q;
  assign x_end     = x1_q;
  assign y_start   = y0_q;
  assign y_end     = y1_q;
  assign x_init    = roi_x0;
  assign y_init    = roi_y0;
  // One-off row base at start; per-pixel addressing stays incremental.
  assign addr_init = ADDR_WIDTH'(roi_y0) * ADDR_WIDTH'(ROW_SIZE) + ADDR_WIDTH'(roi_x0);
  assign empty_roi = (roi_x1 < roi_x0) || (roi_y1 < roi_y0);
`else
  assign x_start   = '0;
  assign x_end     = ROW_WIDTH'(ROW_SIZE - 1);
  assign y_start   = '0;
  assign y_end     = COL_WIDTH'(COL_SIZE - 1);
  assign x_init    = '0;
  assign y_init    = '0;
  assign addr_init = '0;
  assign empty_roi = 1'b0;
`endif

  // Read issue with credit: reads in flight plus FIFO entries never exceed the FIFO depth.
  logic [CntW-1:0] inflight_q, inflight_d, cnt_q, cnt_d;
  logic [CntW:0]   occ;
  logic            issue, last_xy, push, pop;
  tag_t            tag_in;

  assign occ     = {1'b0, inflight_q} + {1'b0, cnt_q};
  assign issue   = (state_q == StScan) && (occ < (CntW + 1)'(Depth));
  assign last_xy = (x_q == x_end) && (y_q == y_end);

  always_comb begin
    tag_in     = '0;
    tag_in.x   = x_q;
    tag_in.y   = y_q;
    tag_in.sof = (x_q == x_start) && (y_q == y_start);
    tag_in.eol = (x_q == x_end);
    tag_in.eof = last_xy;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q    <= '0;
      y_q    <= '0;
      addr_q <= '0;
    end else if (start_acc) begin
      x_q    <= x_init;
      y_q    <= y_init;
      addr_q <= addr_init;
    end else if (issue) begin
      if (x_q == x_end) begin
        x_q    <= x_start;
        y_q    <= y_q + 1'b1;
        // Skip the columns outside the window to land on the next row's first pixel.
        addr_q <= addr_q + ADDR_WIDTH'(ROW_SIZE) - ADDR_WIDTH'(x_end) + ADDR_WIDTH'(x_start);
      end else begin
        x_q    <= x_q + 1'b1;
        addr_q <= addr_q + 1'b1;
      end
    end
  end

  // Tag pipe aligned with the memory read latency.
  logic [RD_LATENCY-1:0] pipe_vld_q;
  tag_t                  pipe_tag_q [RD_LATENCY];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_vld_q <= '0;
    end else begin
      pipe_vld_q[0] <= issue;
      for (int i = 1; i < RD_LATENCY; i++) pipe_vld_q[i] <= pipe_vld_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    pipe_tag_q[0] <= tag_in;
    for (int i = 1; i < RD_LATENCY; i++) pipe_tag_q[i] <= pipe_tag_q[i-1];
  end

  // Output FIFO.
  entry_t          fifo_q [Depth];
  entry_t          head;
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;

  function automatic logic [PtrW-1:0] ptr_next(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign push       = pipe_vld_q[RD_LATENCY-1];
  assign pix_valid  = (cnt_q != '0);
  assign pop        = pix_valid && pix_ready;
  assign inflight_d = inflight_q + CntW'(issue) - CntW'(push);
  assign cnt_d      = cnt_q + CntW'(push) - CntW'(pop);

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= '{data: mem_rd_data, tag: pipe_tag_q[RD_LATENCY-1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      inflight_q <= '0;
    end else begin
      if (push) wr_ptr_q <= ptr_next(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_next(rd_ptr_q);
      cnt_q      <= cnt_d;
      inflight_q <= inflight_d;
    end
  end

  assign head     = fifo_q[rd_ptr_q];
  assign pix_data = pix_valid ? head.data    : '0;
  assign pix_x    = pix_valid ? head.tag.x   : '0;
  assign pix_y    = pix_valid ? head.tag.y   : '0;
  assign pix_sof  = pix_valid && head.tag.sof;
  assign pix_eol  = pix_valid && head.tag.eol;
  assign pix_eof  = pix_valid && head.tag.eof;

  // Control FSM. DRAIN looks at next-cycle occupancy so done lands right after the eof pop.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = empty_roi ? StDrain : StScan;
      StScan:  if (issue && last_xy) state_d = StDrain;
      StDrain: if (cnt_d == '0 && inflight_d == '0) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  assign busy        = (state_q == StScan) || (state_q == StDrain);
  assign done        = (state_q == StDone);
  assign mem_rd_en   = issue;
  assign mem_rd_addr = addr_q;

endmodule

// File: tb/tb_image_cache_reader.sv
// Testbench for image_cache_reader: 4x3 image, read latency 2, cache holds mem[a] = a.
module tb_image_cache_reader;
  localparam int unsigned RS = 4;
  localparam int unsigned CS = 3;
  localparam int unsigned WS = 8;
  localparam int unsigned RW = 3;
  localparam int unsigned CW = 2;
  localparam int unsigned AW = 4;
  localparam int unsigned RL = 2;

  typedef struct packed {
    logic [WS-1:0] data;
    logic [RW-1:0] x;
    logic [CW-1:0] y;
    logic          sof;
    logic          eol;
    logic          eof;
  } pix_t;

  typedef struct {
    int mode;     // 0: ready high, 1: ready 1,0,0,1 pattern, 2: ready low for 20 cycles
    int exp_lat;  // cycles from start to first pix_valid
    int exp_occ;  // max reads outstanding (issued minus accepted)
    int exp_npix;
  } scen_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          pix_ready = 1'b0;
  logic          busy, done, mem_rd_en, pix_valid, pix_sof, pix_eol, pix_eof;
  logic [AW-1:0] mem_rd_addr;
  logic [WS-1:0] mem_rd_data, pix_data;
  logic [RW-1:0] pix_x;
  logic [CW-1:0] pix_y;
`ifdef IMAGE_CACHE_READER_ROI_EN
  logic [RW-1:0] roi_x0 = 3'd0, roi_x1 = 3'd3;
  logic [CW-1:0] roi_y0 = 2'd0, roi_y1 = 2'd2;
`endif

  image_cache_reader #(
    .ROW_SIZE(RS), .COL_SIZE(CS), .WORD_SIZE(WS), .ROW_WIDTH(RW), .COL_WIDTH(CW),
    .ADDR_WIDTH(AW), .RD_LATENCY(RL)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
`ifdef IMAGE_CACHE_READER_ROI_EN
    .roi_x0(roi_x0),
    .roi_x1(roi_x1),
    .roi_y0(roi_y0),
    .roi_y1(roi_y1),
`endif
    .start(start),
    .busy(busy),
    .done(done),
    .mem_rd_en(mem_rd_en),
    .mem_rd_addr(mem_rd_addr),
    .mem_rd_data(mem_rd_data),
    .pix_valid(pix_valid),
    .pix_ready(pix_ready),
    .pix_data(pix_data),
    .pix_x(pix_x),
    .pix_y(pix_y),
    .pix_sof(pix_sof),
    .pix_eol(pix_eol),
    .pix_eof(pix_eof)
  );

  always #5 clk = ~clk;

  // Cache model: two-stage read pipe, contents equal to the address.
  logic [WS-1:0] d1, d2;
  always_ff @(posedge clk) begin
    d1 <= mem_rd_en ? WS'(mem_rd_addr) : 8'hEE;
    d2 <= d1;
  end
  assign mem_rd_data = d2;

  int   n_cmp = 0, n_bad = 0;
  int   idx, issued, cyc, first_lat, max_occ, mode;
  bit   done_seen, eof_prev, prev_stall, inject_done;
  pix_t prev_pix;
  pix_t exp_q[$];
  pix_t full_tab[12];
  pix_t roi_tab[4];
  scen_t scen[3];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic pix_t cur_pix();
    return {pix_data, pix_x, pix_y, pix_sof, pix_eol, pix_eof};
  endfunction

  function automatic logic [63:0] all_out();
    return {40'd0, busy, done, mem_rd_en, mem_rd_addr, pix_valid, pix_data, pix_x, pix_y,
            pix_sof, pix_eol, pix_eof};
  endfunction

  // Processes the current cycle at its sample point, then advances one clock.
  task automatic step(input bit inject);
    int occ;
    unique case (mode)
      1:       pix_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      2:       pix_ready = (cyc >= 20);
      default: pix_ready = 1'b1;
    endcase
    start = inject && (idx == 5) && !inject_done;
    if (start) inject_done = 1'b1;
    if (done) start = 1'b1;  // a start in the DONE cycle must be ignored
    if (mode == 2 && cyc == 20) begin
      chk("stall_reads", issued, 4);
      chk("stall_valid", pix_valid, 1);
      chk("stall_data", pix_data, 0);
    end
    if (mem_rd_en) issued++;
    occ = issued - idx;
    if (occ > max_occ) max_occ = occ;
    if (prev_stall) chk("hold_stable", {pix_valid, cur_pix()}, {1'b1, prev_pix});
    if (pix_valid && first_lat < 0) first_lat = cyc;
    if (done || eof_prev) chk("done_after_eof", done, eof_prev);
    if (eof_prev) chk("busy_fall", busy, 0);
    if (done) done_seen = 1'b1;
    if (pix_valid && pix_ready) begin
      if (idx < exp_q.size()) chk($sformatf("pix%0d", idx), cur_pix(), exp_q[idx]);
      else chk("pix_count", idx + 1, exp_q.size());
      idx++;
    end
    eof_prev   = pix_valid && pix_ready && pix_eof;
    prev_stall = pix_valid && !pix_ready;
    prev_pix   = cur_pix();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run(input int m, input bit inject, input bit abort);
    mode = m; idx = 0; issued = 0; first_lat = -1; max_occ = 0;
    done_seen = 0; eof_prev = 0; prev_stall = 0; inject_done = 0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc = 1;
    for (int k = 0; k < 200 && !done_seen; k++) begin
      if (abort && idx == 7) break;
      step(inject);
    end
    start = 1'b0;
    if (!abort) begin
      chk("frame_done", done_seen, 1);
      chk("pix_total", idx, exp_q.size());
      for (int k = 0; k < 3; k++) begin
        chk("idle_after_done", {busy, mem_rd_en, pix_valid, done}, 4'b0);
        @(posedge clk);
        #1;
      end
    end
  endtask

  initial begin
    full_tab[0]  = '{8'd0,  3'd0, 2'd0, 1'b1, 1'b0, 1'b0};
    full_tab[1]  = '{8'd1,  3'd1, 2'd0, 1'b0, 1'b0, 1'b0};
    full_tab[2]  = '{8'd2,  3'd2, 2'd0, 1'b0, 1'b0, 1'b0};
    full_tab[3]  = '{8'd3,  3'd3, 2'd0, 1'b0, 1'b1, 1'b0};
    full_tab[4]  = '{8'd4,  3'd0, 2'd1, 1'b0, 1'b0, 1'b0};
    full_tab[5]  = '{8'd5,  3'd1, 2'd1, 1'b0, 1'b0, 1'b0};
    full_tab[6]  = '{8'd6,  3'd2, 2'd1, 1'b0, 1'b0, 1'b0};
    full_tab[7]  = '{8'd7,  3'd3, 2'd1, 1'b0, 1'b1, 1'b0};
    full_tab[8]  = '{8'd8,  3'd0, 2'd2, 1'b0, 1'b0, 1'b0};
    full_tab[9]  = '{8'd9,  3'd1, 2'd2, 1'b0, 1'b0, 1'b0};
    full_tab[10] = '{8'd10, 3'd2, 2'd2, 1'b0, 1'b0, 1'b0};
    full_tab[11] = '{8'd11, 3'd3, 2'd2, 1'b0, 1'b1, 1'b1};
    roi_tab[0]   = '{8'd5,  3'd1, 2'd1, 1'b1, 1'b0, 1'b0};
    roi_tab[1]   = '{8'd6,  3'd2, 2'd1, 1'b0, 1'b1, 1'b0};
    roi_tab[2]   = '{8'd9,  3'd1, 2'd2, 1'b0, 1'b0, 1'b0};
    roi_tab[3]   = '{8'd10, 3'd2, 2'd2, 1'b0, 1'b1, 1'b1};
    scen[0] = '{0, 4, 4, 12};
    scen[1] = '{1, 4, 4, 12};
    scen[2] = '{2, 4, 4, 12};

    exp_q = {};
    for (int i = 0; i < 12; i++) exp_q.push_back(full_tab[i]);

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", all_out(), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Full frames under different backpressure patterns.
    for (int s = 0; s < 3; s++) begin
      run(scen[s].mode, 1'b0, 1'b0);
      chk($sformatf("latency_m%0d", scen[s].mode), first_lat, scen[s].exp_lat);
      chk($sformatf("max_occ_m%0d", scen[s].mode), max_occ, scen[s].exp_occ);
      chk($sformatf("npix_m%0d", scen[s].mode), idx, scen[s].exp_npix);
    end

    // Start while busy is ignored; reset mid-frame aborts; restart from (0,0).
    run(0, 1'b1, 1'b1);
    chk("abort_at_pix7", idx, 7);
    rst_n = 1'b0;
    #1;
    chk("abort_outputs", all_out(), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run(0, 1'b0, 1'b0);
    chk("restart_latency", first_lat, 4);

`ifdef IMAGE_CACHE_READER_ROI_EN
    roi_x0 = 3'd1; roi_x1 = 3'd2; roi_y0 = 2'd1; roi_y1 = 2'd2;
    exp_q = {};
    for (int i = 0; i < 4; i++) exp_q.push_back(roi_tab[i]);
    run(0, 1'b0, 1'b0);
    chk("roi_latency", first_lat, 4);

    // Empty window: done two cycles after start, no reads, no pixels.
    roi_x0 = 3'd3; roi_x1 = 3'd1; roi_y0 = 2'd0; roi_y1 = 2'd2;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      chk($sformatf("empty_done_c%0d", c), done, (c == 2));
      chk($sformatf("empty_quiet_c%0d", c), {mem_rd_en, pix_valid}, 2'b00);
      @(posedge clk);
      #1;
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
